// File: rtl/wb_regfile_if.sv
// wb_regfile_if: writeback, read and forwarding signals of the register file.
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              MemtoReg;
    logic              RegWrite;
    logic [ADDR_W-1:0] Write_address;
    logic [DATA_W-1:0] aluresult;
    logic [DATA_W-1:0] memdata;
    logic [ADDR_W-1:0] Read_address1;
    logic [ADDR_W-1:0] Read_address2;
    logic [DATA_W-1:0] Read_data1;
    logic [DATA_W-1:0] Read_data2;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [31:0]       wb_count;

    modport master (
        output MemtoReg, RegWrite, Write_address, aluresult, memdata, Read_address1, Read_address2,
        input  Read_data1, Read_data2, wb_valid, wb_addr, wb_data, wb_count
    );

    modport slave (
        input  MemtoReg, RegWrite, Write_address, aluresult, memdata, Read_address1, Read_address2,
        output Read_data1, Read_data2, wb_valid, wb_addr, wb_data, wb_count
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: two-read one-write register file with write-first bypass and writeback counter.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic        clk,
    input logic        rst_n,
    wb_regfile_if.slave bus
);
    localparam int N = 2 ** ADDR_W;

    logic [DATA_W-1:0] entry_q [N];
    logic [DATA_W-1:0] entry_d [N];
    logic [31:0]       wb_count_q, wb_count_d;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;

    assign wdata        = bus.MemtoReg ? bus.memdata : bus.aluresult;
    assign wvalid       = rst_n && bus.RegWrite && (bus.Write_address != '0);
    assign bus.wb_data  = wdata;
    assign bus.wb_valid = wvalid;
    assign bus.wb_addr  = bus.Write_address;
    assign bus.wb_count = wb_count_q;

    // wvalid is low in reset, so the bypass is disabled there as well
    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
        return (a == '0) ? '0 : (wvalid && bus.Write_address == a) ? wdata : entry_q[a];
    endfunction

    assign bus.Read_data1 = rd(bus.Read_address1);
    assign bus.Read_data2 = rd(bus.Read_address2);

    always_comb begin
        entry_d = entry_q;
        if (wvalid) entry_d[bus.Write_address] = wdata;
        wb_count_d = wb_count_q + 32'(wvalid);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry_q    <= '{default: '0};
            wb_count_q <= '0;
        end else begin
            entry_q    <= entry_d;
            wb_count_q <= wb_count_d;
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: random and directed stimulus against an array-based reference model.
module tb_wb_regfile;
    logic clk = 0;
    logic rst_n = 0;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] mem [32];
    logic [31:0] cnt = 0;

    always #5 clk = ~clk;

    wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic v, input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 0;
        if (v && wa == a) return wd;
        return mem[a];
    endfunction

    task automatic step(input logic r, input logic we, input logic m2r, input logic [4:0] wa,
                        input logic [31:0] alu, input logic [31:0] md, input logic [4:0] a1, input logic [4:0] a2);
        logic [31:0] wd;
        logic v;
        @(negedge clk);
        rst_n = r;
        bus.RegWrite = we;
        bus.MemtoReg = m2r;
        bus.Write_address = wa;
        bus.aluresult = alu;
        bus.memdata = md;
        bus.Read_address1 = a1;
        bus.Read_address2 = a2;
        wd = m2r ? md : alu;
        v = r && we && wa != 0;
        #1;
        chk("wb_data", bus.wb_data, wd);
        chk("wb_valid", bus.wb_valid, v);
        chk("wb_addr", bus.wb_addr, wa);
        chk("rd1", bus.Read_data1, exp_rd(a1, v, wa, wd));
        chk("rd2", bus.Read_data2, exp_rd(a2, v, wa, wd));
        chk("count", bus.wb_count, cnt);
        @(posedge clk);
        if (!r) begin
            foreach (mem[i]) mem[i] = 0;
            cnt = 0;
        end else if (v) begin
            mem[wa] = wd;
            cnt = cnt + 1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] wa, a1, a2;
        foreach (mem[i]) mem[i] = 0;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 4, 32'h77, 0, 4, 0);
        // basic write then array read
        step(1, 1, 0, 5, 32'h1234, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 5, 0);
        chk("r034_data", bus.Read_data1, 32'h1234);
        chk("r034_count", bus.wb_count, 1);
        // same-cycle bypass from memdata
        step(1, 1, 1, 7, 0, 32'hDEADBEEF, 0, 7);
        // write to register 0 is dropped
        step(1, 1, 0, 0, 32'hFFFFFFFF, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("r036_count", bus.wb_count, 2);
        // RegWrite low leaves entry 3 alone
        step(1, 1, 0, 3, 32'h11, 0, 0, 0);
        step(1, 0, 1, 3, 32'h55, 32'h66, 3, 3);
        step(1, 0, 0, 0, 0, 0, 3, 0);
        chk("r037_data", bus.Read_data1, 32'h11);
        // write on a reset edge is discarded
        step(1, 1, 0, 9, 32'hAA, 0, 9, 0);
        step(0, 1, 0, 9, 32'hBB, 0, 9, 9);
        step(1, 0, 0, 0, 0, 0, 9, 9);
        chk("r038_data", bus.Read_data1, 0);
        chk("r038_count", bus.wb_count, 0);
        for (int i = 0; i < 400; i++) begin
            wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
            a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
            step($urandom_range(0, 19) != 0, 1'($urandom), 1'($urandom), wa, $urandom, $urandom, a1, a2);
        end
        // counter wrap via deposit
        @(negedge clk);
        bus.RegWrite = 0;
        force dut.wb_count_q = 32'hFFFFFFFF;
        #1 release dut.wb_count_q;
        cnt = 32'hFFFFFFFF;
        step(1, 1, 0, 12, 32'h5A5A, 0, 12, 0);
        #1;
        chk("r039_wrap", bus.wb_count, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, default 32, width of the register data word and both writeback sources.
REQ-002 Parameter ADDR_W, default 5, register address width; the file holds 2**ADDR_W entries.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, reset; synchronous and active-low.
REQ-005 Port MemtoReg, input, 1, writeback source select from the MEM/WB stage: 1 selects memdata, 0 selects aluresult.
REQ-006 Port RegWrite, input, 1, writeback enable from the MEM/WB stage.
REQ-007 Port Write_address, input, ADDR_W, destination register of the writeback.
REQ-008 Port aluresult, input, DATA_W, ALU result from the MEM/WB stage.
REQ-009 Port memdata, input, DATA_W, load data from the MEM/WB stage.
REQ-010 Ports Read_address1 and Read_address2, input, ADDR_W each, decode-stage read addresses.
REQ-011 Ports Read_data1 and Read_data2, output, DATA_W each, decode-stage read data; combinational.
REQ-012 Port wb_valid, output, 1, the writeback in flight this cycle commits; combinational.
REQ-013 Port wb_addr, output, ADDR_W, destination of the in-flight writeback, for the forwarding unit.
REQ-014 Port wb_data, output, DATA_W, selected writeback value, for the forwarding unit.
REQ-015 Port wb_count, output, 32, registered count of committed writebacks.

Function
REQ-016 wb_data SHALL equal memdata when MemtoReg=1 and aluresult when MemtoReg=0, every cycle.
REQ-017 wb_valid SHALL be 1 iff rst_n=1, RegWrite=1 and Write_address!=0.
REQ-018 wb_addr SHALL equal Write_address every cycle.
REQ-019 On a rising clk edge with wb_valid=1, entry[Write_address] SHALL take wb_data.
REQ-020 No entry SHALL change on an edge with wb_valid=0.
REQ-021 Entry 0 SHALL never be written and SHALL always read as 0.
REQ-022 Read path, per port n: address 0 -> 0.
REQ-023 Read path, per port n: else if wb_valid=1 and Write_address==Read_addressn -> wb_data (write-first bypass, 0-cycle visibility).
REQ-024 Read path, per port n: otherwise -> entry[Read_addressn].
REQ-025 Both read ports SHALL be independent; equal read addresses SHALL return identical data.
REQ-026 A write becomes visible through the array path on the cycle after its edge; the bypass covers the write cycle itself.
REQ-027 wb_count SHALL increment by 1 on each edge with wb_valid=1 and wrap from 0xFFFFFFFF to 0 with no flag.
REQ-028 Writes with RegWrite=1 and Write_address=0 SHALL not increment wb_count.
REQ-029 MemtoReg SHALL be ignored when RegWrite=0.

Reset
REQ-030 On a rising clk edge with rst_n=0, entries 1..2**ADDR_W-1 SHALL clear to 0 and wb_count SHALL clear to 0.
REQ-031 A write presented on a reset edge SHALL be discarded and SHALL not be counted.
REQ-032 While rst_n=0, wb_valid=0 and the bypass SHALL be disabled; reads return the array contents.
REQ-033 Deasserting reset mid-stream SHALL require no warm-up; a write on the first edge with rst_n=1 commits.

Verification
REQ-034 Reset then RegWrite=1, addr 5, MemtoReg=0, aluresult=0x1234 -> next cycle Read_data1 (addr 5)=0x1234, wb_count=1.
REQ-035 Same-cycle bypass: write addr 7, MemtoReg=1, memdata=0xDEADBEEF, Read_address2=7 -> Read_data2=0xDEADBEEF in that cycle.
REQ-036 Write to addr 0 with aluresult=0xFFFFFFFF -> Read_data1 (addr 0)=0 in that cycle and after, wb_count unchanged, wb_valid=0.
REQ-037 RegWrite=0, addr 3, aluresult=0x55 -> entry 3 keeps its prior value, wb_count unchanged.
REQ-038 Write addr 9=0xAA, then assert rst_n=0 for one edge while writing addr 9=0xBB -> Read_data (addr 9)=0 and wb_count=0 after reset.
REQ-039 Force wb_count to 0xFFFFFFFF via 2**32-1 writes or a hierarchical deposit, then one valid write -> wb_count=0.
